maze_map_sram: RTL and testbench
================================

// Module: maze_map_sram
// PURPOSE
//  Memory-side responder for the maze router's SRAM bus (address/cs/we/data).
//  Holds the 8x8 grid map (0x00-0x3F) and terminal list (0x80 up). A host preloads it
//  through a load port; the router reads it and writes back path cells.
//  When the router raises its done flag, the block streams the final grid out on a
//  dump port for checking.
// PARAMETERS
//  DATA_WIDTH   8     word width
//  ADDR_WIDTH   8     address width; array depth = 2**ADDR_WIDTH
//  GRID_CELLS   64    words dumped, addresses 0..GRID_CELLS-1
//  EMPTY_FILL   8'hFF read value for never-written words (XFILL_EN undefined)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high
//  r_cs       in   1   router chip select
//  r_we       in   1   router write enable (1=write, 0=read)
//  r_addr     in   8   router address
//  r_wdata    in   8   router write data (router data_out)
//  r_rdata    out  8   router read data (router data_in)
//  ld_valid   in   1   host load request
//  ld_ready   out  1   load accepted when ld_valid & ld_ready
//  ld_addr    in   8   load address
//  ld_data    in   8   load data
//  done_in    in   1   router done/fail flag (router D)
//  dmp_valid  out  1   dump word valid
//  dmp_ready  in   1   dump sink ready
//  dmp_addr   out  8   dump word address
//  dmp_data   out  8   dump word data
//  dmp_last   out  1   high with the final dump word (addr GRID_CELLS-1)
//  wr_count   out  8   router writes since reset, saturates at 8'hFF
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Storage: 2**ADDR_WIDTH x DATA_WIDTH array plus a per-word valid bit.
//  - Reset clears all valid bits, wr_count, r_rdata, all dump outputs and busy; state <= IDLE.
//    Array contents are not cleared.
//  - Router read (r_cs & ~r_we): r_rdata <= mem[r_addr] on that edge, giving 1-cycle latency.
//    Word issued at edge N is stable through cycle N+1, so address k presented cycle k is
//    sampled by the router in cycle k+1. An invalid word returns the fill (see CONFIGURATION).
//  - Router write (r_cs & r_we): mem[r_addr] <= r_wdata, valid set, wr_count +1 (saturating).
//    r_rdata holds its previous value.
//  - r_cs=0: r_rdata holds. The router bus is served in every state.
//  - Load port: ld_ready = ~r_cs & (state==IDLE), combinational. An accepted load writes
//    mem[ld_addr] and sets valid, with no wr_count change. The router always wins same-cycle
//    conflicts: ld_ready=0 and the host holds its request.
//  - FSM:
//      IDLE: rising edge of done_in (registered compare) -> DUMP, dump index i <= 0.
//      DUMP: fetch mem[i] into dmp_data, dmp_addr <= i, dmp_valid <= 1.
//            Outputs hold while dmp_valid & ~dmp_ready.
//            On handshake: i==GRID_CELLS-1 -> DONE, dmp_valid <= 0; else i+1 and next word
//            presented the following cycle.
//            Sustained throughput is 1 word/cycle when dmp_ready stays high.
//      DONE: dump outputs 0. Leaves to IDLE when done_in=0.
//  - dmp_last = dmp_valid & (dmp_addr==GRID_CELLS-1).
//  - Dump read port is independent of the router port. Router writes during DUMP hit the array;
//    a word already presented is not updated.
//  - Reset mid-dump aborts immediately: dmp_valid=0 the next cycle, state IDLE.
//  - Addresses wrap modulo 2**ADDR_WIDTH; no out-of-range condition exists.
// CONFIGURATION
//  XFILL_EN defined: invalid words read as {DATA_WIDTH{1'bx}}. The router detects the end of
//    the terminal list with ===8'hxx, so this is the mode for simulation benches.
//  XFILL_EN undefined: invalid words read as EMPTY_FILL. Synthesizable; no X on r_rdata.
// TESTING
//  1 Load 0x00-0x3F=8'h00, 0x80=8'h05, 0x81=8'h3A, then router read burst 0..0x81 ->
//    r_rdata lags address by one cycle with matching values; read 0x82 -> 8'hxx
//    (XFILL_EN) / 8'hFF (not).
//  2 r_cs=1 and ld_valid=1 in the same cycle -> ld_ready=0, load completes the first cycle r_cs=0,
//    memory holds ld_data.
//  3 Router writes 8'h00 to 0x05, 0x0D, 0x15 -> wr_count=3; 300 writes -> wr_count stays 8'hFF.
//  4 done_in 0->1 with dmp_ready=1 -> 64 consecutive words, addr 0..0x3F, dmp_last only on 0x3F,
//    busy high until done_in drops.
//  5 dmp_ready toggled randomly -> no word lost or duplicated; data and addr stable while stalled.
//  6 Reset asserted at dump word 20 -> dmp_valid=0 next cycle, wr_count=0, and a reread of a
//    loaded word returns the fill (valid cleared).

Source files
------------

// File: rtl/maze_map_sram.sv
`default_nettype none
// ============================================================================
// Module      : maze_map_sram
// Description : Memory-side responder for the maze router's SRAM bus.
//               Holds the 8x8 grid map (0x00-0x3F) and the terminal list
//               (0x80 up). A host preloads words through a load port, the
//               router reads and writes the array, and on a rising edge of
//               the router's done flag the grid is streamed out on a
//               valid/ready dump port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset            clock, synchronous active-high reset
//   r_cs/r_we/r_addr/     router bus: 1-cycle read latency, writes counted
//   r_wdata/r_rdata
//   ld_valid/ld_ready/    host load port; router has priority, loads only
//   ld_addr/ld_data       accepted while IDLE
//   done_in               router done/fail flag, rising edge starts a dump
//   dmp_valid/dmp_ready/  grid dump stream, addresses 0..GRID_CELLS-1,
//   dmp_addr/dmp_data/    dmp_last flags the final word
//   dmp_last
//   wr_count              router writes since reset, saturating
//   busy                  high whenever the dump FSM is not idle
// Configuration macro
//   XFILL_EN : when defined, never-written words read as all-X (simulation
//              mode); otherwise they read as EMPTY_FILL.
// ============================================================================
module maze_map_sram #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    GRID_CELLS = 64,
    parameter logic [DATA_WIDTH-1:0] EMPTY_FILL = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    // router bus
    input  logic                  r_cs,
    input  logic                  r_we,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_wdata,
    output logic [DATA_WIDTH-1:0] r_rdata,
    // host load port
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    // dump control / stream
    input  logic                  done_in,
    output logic                  dmp_valid,
    input  logic                  dmp_ready,
    output logic [ADDR_WIDTH-1:0] dmp_addr,
    output logic [DATA_WIDTH-1:0] dmp_data,
    output logic                  dmp_last,
    // status
    output logic [7:0]            wr_count,
    output logic                  busy
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(GRID_CELLS - 1);

`ifdef XFILL_EN
    // Router bench detects end of terminal list with ===8'hxx.
    localparam logic [DATA_WIDTH-1:0] c_FILL = {DATA_WIDTH{1'bx}};
`else
    localparam logic [DATA_WIDTH-1:0] c_FILL = EMPTY_FILL;
`endif

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_DUMP = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [c_DEPTH-1:0]    r_valid;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_done_d;

    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [7:0]            r_wr_count;

    logic                  r_dmp_valid;
    logic [ADDR_WIDTH-1:0] r_dmp_addr;
    logic [DATA_WIDTH-1:0] r_dmp_data;
    logic [ADDR_WIDTH-1:0] r_idx;

    logic                  w_rtr_rd;
    logic                  w_rtr_wr;
    logic                  w_ld_acc;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [DATA_WIDTH-1:0] w_rtr_word;
    logic [DATA_WIDTH-1:0] w_dmp_word;
    logic                  w_done_rise;
    logic                  w_dmp_fire;
    logic                  w_dmp_final;

    assign w_rtr_rd  = r_cs & ~r_we;
    assign w_rtr_wr  = r_cs & r_we;
    assign w_ld_acc  = ld_valid & ld_ready;

    // Load port only ever sees a free cycle (ld_ready excludes r_cs), so a
    // single write port muxed toward the router is sufficient.
    assign w_wr_en   = (w_rtr_wr | w_ld_acc) & ~reset;
    assign w_wr_addr = w_rtr_wr ? r_addr  : ld_addr;
    assign w_wr_data = w_rtr_wr ? r_wdata : ld_data;

    assign w_rtr_word = r_valid[r_addr] ? r_mem[r_addr] : c_FILL;
    assign w_dmp_word = r_valid[r_idx]  ? r_mem[r_idx]  : c_FILL;

    assign w_done_rise = done_in & ~r_done_d;
    assign w_dmp_fire  = r_dmp_valid & dmp_ready;
    assign w_dmp_final = w_dmp_fire & (r_dmp_addr == c_LAST);

    // Array contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_wr_en) begin
            r_valid[w_wr_addr] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Router read data and write counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (w_rtr_rd) begin
            r_rd_data <= w_rtr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_count <= '0;
        end else if (w_rtr_wr && (r_wr_count != 8'hFF)) begin
            r_wr_count <= r_wr_count + 8'd1;
        end
    end

    // Tracks done_in through reset as well, so a flag that stays high
    // across reset is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        r_done_d <= done_in;
    end

    // ------------------------------------------------------------------
    // Dump FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dump FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_done_rise) w_state_nxt = c_S_DUMP;
            c_S_DUMP: if (w_dmp_final) w_state_nxt = c_S_DONE;
            c_S_DONE: if (!done_in)    w_state_nxt = c_S_IDLE;
            default:                   w_state_nxt = c_S_IDLE;
        endcase
    end

    // Dump FSM: combinational outputs
    always_comb begin
        ld_ready = 1'b0;
        busy     = 1'b0;
        dmp_last = 1'b0;
        ld_ready = ~r_cs & (r_state == c_S_IDLE);
        busy     = (r_state != c_S_IDLE);
        dmp_last = r_dmp_valid & (r_dmp_addr == c_LAST);
    end

    // ------------------------------------------------------------------
    // Dump datapath. A new word is loaded whenever the output slot is
    // empty or being consumed, giving one word per cycle under constant
    // ready. The word is captured at presentation time, so later router
    // writes to that address do not alter a word already on the port.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dmp_valid <= 1'b0;
            r_dmp_addr  <= '0;
            r_dmp_data  <= '0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                c_S_DUMP: begin
                    if (!r_dmp_valid || dmp_ready) begin
                        if (w_dmp_final) begin
                            r_dmp_valid <= 1'b0;
                            r_dmp_addr  <= '0;
                            r_dmp_data  <= '0;
                        end else begin
                            r_dmp_valid <= 1'b1;
                            r_dmp_addr  <= r_idx;
                            r_dmp_data  <= w_dmp_word;
                            r_idx       <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_dmp_valid <= 1'b0;
                    r_dmp_addr  <= '0;
                    r_dmp_data  <= '0;
                    r_idx       <= '0;
                end
            endcase
        end
    end

    assign r_rdata   = r_rd_data;
    assign wr_count  = r_wr_count;
    assign dmp_valid = r_dmp_valid;
    assign dmp_addr  = r_dmp_addr;
    assign dmp_data  = r_dmp_data;

endmodule
`default_nettype wire

// File: tb/tb_maze_map_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_map_sram
// Description : Self-checking bench for maze_map_sram. A reference model of
//               the memory (data + written flags), the write counter and the
//               dump sequence is kept as plain arrays and integers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_map_sram;

    logic       clk = 1'b0;
    logic       reset;
    logic       r_cs, r_we;
    logic [7:0] r_addr, r_wdata, r_rdata;
    logic       ld_valid, ld_ready;
    logic [7:0] ld_addr, ld_data;
    logic       done_in;
    logic       dmp_valid, dmp_ready, dmp_last;
    logic [7:0] dmp_addr, dmp_data;
    logic [7:0] wr_count;
    logic       busy;

    always #5 clk = ~clk;

    maze_map_sram dut (
        .clk       (clk),
        .reset     (reset),
        .r_cs      (r_cs),
        .r_we      (r_we),
        .r_addr    (r_addr),
        .r_wdata   (r_wdata),
        .r_rdata   (r_rdata),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .done_in   (done_in),
        .dmp_valid (dmp_valid),
        .dmp_ready (dmp_ready),
        .dmp_addr  (dmp_addr),
        .dmp_data  (dmp_data),
        .dmp_last  (dmp_last),
        .wr_count  (wr_count),
        .busy      (busy)
    );

`ifdef XFILL_EN
    localparam logic [7:0] FILL = 8'hxx;
`else
    localparam logic [7:0] FILL = 8'hFF;
`endif

    // reference model
    logic [7:0] m_mem   [256];
    bit         m_valid [256];
    int         m_wr_cnt;
    logic [7:0] m_last_rd;

    int tests = 0;
    int fails = 0;

    function automatic logic [7:0] m_rd(input int a);
        return m_valid[a & 255] ? m_mem[a & 255] : FILL;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [7:0] d);
        bit ok = 1'b0;
        ld_valid = 1'b1; ld_addr = 8'(a); ld_data = d;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (ld_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        if (ok) begin
            m_mem[a & 255]   = d;
            m_valid[a & 255] = 1'b1;
        end
        chk("ld_accept", 32'(ok), 32'd1);
    endtask

    task automatic rd(input string tag, input int a);
        r_cs = 1'b1; r_we = 1'b0; r_addr = 8'(a);
        tick();
        r_cs = 1'b0;
        m_last_rd = m_rd(a);
        chk(tag, 32'(r_rdata), 32'(m_last_rd));
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        r_cs = 1'b1; r_we = 1'b1; r_addr = 8'(a); r_wdata = d;
        tick();
        r_cs = 1'b0; r_we = 1'b0;
        m_mem[a & 255]   = d;
        m_valid[a & 255] = 1'b1;
        if (m_wr_cnt < 255) m_wr_cnt++;
        chk("wr_rdata_hold", 32'(r_rdata), 32'(m_last_rd));
    endtask

    // Full dump with optional random back-pressure; expected words come
    // from the model in address order.
    task automatic dump(input bit rnd);
        int idx = 0;
        int first_cyc = -1;
        int last_cyc  = -1;
        bit nr;
        done_in   = 1'b1;
        dmp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int cyc = 0; cyc < 3000 && idx < 64; cyc++) begin
            tick();
            nr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            dmp_ready = nr;
            if (dmp_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                chk("dmp_addr", 32'(dmp_addr), 32'(idx));
                chk("dmp_data", 32'(dmp_data), 32'(m_rd(idx)));
                chk("dmp_last", 32'(dmp_last), 32'(idx == 63));
                chk("dmp_busy", 32'(busy), 32'd1);
                if (nr) idx++;
            end
        end
        chk("dmp_count", 32'(idx), 32'd64);
        if (!rnd) chk("dmp_consecutive", 32'(last_cyc - first_cyc), 32'd63);
        tick();
        chk("done_valid_low", 32'(dmp_valid), 32'd0);
        chk("done_busy_high", 32'(busy), 32'd1);
        done_in = 1'b0;
        tick();
        chk("idle_busy_low", 32'(busy), 32'd0);
        dmp_ready = 1'b0;
    endtask

    initial begin
        bit reached;
        logic [7:0] d;
        reset = 1'b1; r_cs = 1'b0; r_we = 1'b0; r_addr = '0; r_wdata = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        done_in = 1'b0; dmp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin m_mem[i] = '0; m_valid[i] = 1'b0; end
        m_wr_cnt = 0; m_last_rd = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_rdata", 32'(r_rdata), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dmp_valid", 32'(dmp_valid), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);

        // 1: preload and read burst with one-cycle latency
        for (int a = 0; a < 64; a++) load(a, 8'h00);
        load(8'h80, 8'h05);
        load(8'h81, 8'h3A);
        for (int k = 0; k <= 8'h81; k++) begin
            r_cs = 1'b1; r_we = 1'b0; r_addr = 8'(k);
            tick();
            m_last_rd = m_rd(k);
            chk("burst_rdata", 32'(r_rdata), 32'(m_last_rd));
        end
        r_cs = 1'b0;
        rd("term_0x80", 8'h80);
        rd("term_end_fill", 8'h82);
        chk("term_end_fill_const", 32'(r_rdata), 32'(FILL));

        // 2: router/host conflict
        d = 8'($urandom);
        r_cs = 1'b1; r_we = 1'b0; r_addr = 8'h00;
        ld_valid = 1'b1; ld_addr = 8'h40; ld_data = d;
        #1;
        chk("conflict_ready0", 32'(ld_ready), 32'd0);
        tick();
        m_last_rd = m_rd(0);
        chk("conflict_ready0_hold", 32'(ld_ready), 32'd0);
        r_cs = 1'b0;
        #1;
        chk("conflict_ready1", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        m_mem[8'h40] = d; m_valid[8'h40] = 1'b1;
        rd("conflict_mem", 8'h40);

        // 3: write counter, then saturation with random writes
        wr(8'h05, 8'h00);
        wr(8'h0D, 8'h00);
        wr(8'h15, 8'h00);
        chk("wr_count_3", 32'(wr_count), 32'd3);
        for (int n = 0; n < 300; n++) wr(int'($urandom_range(0, 255)), 8'($urandom));
        chk("wr_count_sat", 32'(wr_count), 32'(m_wr_cnt));
        chk("wr_count_ff", 32'(wr_count), 32'hFF);
        for (int n = 0; n < 8; n++) rd("rand_read", int'($urandom_range(0, 255)));

        // 4: full-rate dump
        dump(1'b0);

        // 5: dump under random back-pressure, after fresh random grid data
        for (int n = 0; n < 20; n++) wr(int'($urandom_range(0, 63)), 8'($urandom));
        dump(1'b1);

        // 6: reset in the middle of a dump
        reached   = 1'b0;
        done_in   = 1'b1;
        dmp_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            tick();
            if (dmp_valid && dmp_addr == 8'd20) begin reached = 1'b1; break; end
        end
        chk("reach_word20", 32'(reached), 32'd1);
        reset = 1'b1; done_in = 1'b0; dmp_ready = 1'b0;
        tick();
        chk("abort_dmp_valid", 32'(dmp_valid), 32'd0);
        chk("abort_wr_count", 32'(wr_count), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        m_wr_cnt = 0;
        tick();
        chk("abort_rdata", 32'(r_rdata), 32'd0);
        rd("post_reset_fill_80", 8'h80);
        rd("post_reset_fill_05", 8'h05);
        load(8'h80, 8'h05);
        rd("post_reset_reload", 8'h80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
